// File: rtl/simon_core_param.sv
// simon_core_param: parametrised Simon game core.
// Builds a pseudo-random colour sequence one entry per round and plays it back
// with SHOW_CYCLES lit / GAP_CYCLES dark per colour. It then checks the player's
// presses against the sequence, with an optional input timeout. The best
// completed-round count is kept across games until reset.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start_pulse         one-cycle start/restart (accepted in any state)
//   btn_pulse, btn_idx  one-cycle colour press and its index
//   round               current sequence length (0 in idle)
//   color, color_en     colour being shown and its display enable
//   wait_in             high while player input is accepted
//   win, lose           game-over levels
//   high_score          best completed-round count since reset
module simon_core_param #(
    parameter int NUM_COLORS     = 4,
    parameter int MAX_ROUNDS     = 16,
    parameter int SHOW_CYCLES    = 25000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int STRICT         = 1,
    localparam int CW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1,
    localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_pulse,
    input  logic          btn_pulse,
    input  logic [2:0]    btn_idx,
    output logic [RW-1:0] round,
    output logic [CW-1:0] color,
    output logic          color_en,
    output logic          wait_in,
    output logic          win,
    output logic          lose,
    output logic [RW-1:0] high_score
);
    localparam int IW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
    } state_t;

    state_t        state, state_d;
    logic [15:0]   lfsr, lfsr_d, lfsr_adv;
    logic [15:0]   seed;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] play_idx, play_d;
    logic [RW-1:0] in_idx, in_d;
    logic [RW-1:0] hs, hs_d;
    logic [RW-1:0] rm1;
    logic [31:0]   tmr, tmr_d;
    logic [CW-1:0] seq [MAX_ROUNDS];
    logic [CW-1:0] new_col;
    logic          seq_we;
    logic          btn_ok, hit, timeout;

    // Galois step, right shift, taps folded in when the outgoing lsb is 1.
    assign lfsr_adv = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign new_col  = CW'(lfsr[7:0] % 8'(NUM_COLORS));
    assign rm1      = round_q - RW'(1);

    // Out-of-range indices are not presses at all: no miss, no timer reset.
    assign btn_ok  = btn_pulse && ({1'b0, btn_idx} < 4'(NUM_COLORS));
    assign hit     = (btn_idx[CW-1:0] == seq[in_idx[IW-1:0]]);
    assign timeout = (TIMEOUT_CYCLES != 0) && (tmr == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state;
        lfsr_d  = lfsr;
        round_d = round_q;
        play_d  = play_idx;
        in_d    = in_idx;
        tmr_d   = tmr;
        hs_d    = hs;
        seq_we  = 1'b0;
        case (state)
            S_ADD: begin
                seq_we  = 1'b1;
                lfsr_d  = lfsr_adv;
                round_d = round_q + RW'(1);
                play_d  = '0;
                tmr_d   = '0;
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tmr == 32'(SHOW_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = S_SHOW_OFF;
                end else begin
                    tmr_d = tmr + 32'd1;
                end
            end
            S_SHOW_OFF: begin
                if (tmr == 32'(GAP_CYCLES - 1)) begin
                    tmr_d = '0;
                    if (play_idx == rm1) begin
                        in_d    = '0;
                        state_d = S_WAIT_IN;
                    end else begin
                        play_d  = play_idx + RW'(1);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    tmr_d = tmr + 32'd1;
                end
            end
            S_WAIT_IN: begin
                if (btn_ok && hit) begin
                    tmr_d = '0;
                    if (in_idx == rm1) begin
                        if (round_q == RW'(MAX_ROUNDS)) begin
                            hs_d    = RW'(MAX_ROUNDS);
                            state_d = S_WIN;
                        end else begin
                            state_d = S_ADD;
                        end
                    end else begin
                        in_d = in_idx + RW'(1);
                    end
                end else if (btn_ok || timeout) begin
                    if (STRICT != 0) begin
                        hs_d    = (rm1 > hs) ? rm1 : hs;
                        state_d = S_LOSE;
                    end else begin
                        // Lenient miss: replay the same round from the top.
                        play_d  = '0;
                        tmr_d   = '0;
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    tmr_d = tmr + 32'd1;
                end
            end
            default: ;  // IDLE, WIN, LOSE hold until start
        endcase

        // Restart overrides anything the current state (or a press) wanted.
        if (start_pulse) begin
            lfsr_d  = seed | 16'h0001;
            round_d = '0;
            tmr_d   = '0;
            hs_d    = hs;
            seq_we  = 1'b0;
            state_d = S_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            lfsr     <= 16'h0001;
            seed     <= '0;
            round_q  <= '0;
            play_idx <= '0;
            in_idx   <= '0;
            tmr      <= '0;
            hs       <= '0;
        end else begin
            state    <= state_d;
            lfsr     <= lfsr_d;
            seed     <= seed + 16'd1;
            round_q  <= round_d;
            play_idx <= play_d;
            in_idx   <= in_d;
            tmr      <= tmr_d;
            hs       <= hs_d;
        end
    end

    // Sequence contents are don't-care after reset; only valid entries are read.
    always_ff @(posedge clk) begin
        if (seq_we) seq[round_q[IW-1:0]] <= new_col;
    end

    assign round      = round_q;
    assign color      = (state == S_SHOW_ON) ? seq[play_idx[IW-1:0]] : '0;
    assign color_en   = (state == S_SHOW_ON);
    assign wait_in    = (state == S_WAIT_IN);
    assign win        = (state == S_WIN);
    assign lose       = (state == S_LOSE);
    assign high_score = hs;
endmodule

// File: tb/tb_simon_core_param.sv
module tb_simon_core_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_pulse = 1'b0;
    logic       btn_pulse = 1'b0;
    logic [2:0] btn_idx = 3'd0;

    // strict, timeout 50
    logic [1:0] round_s, color_s, hs_s;
    logic       cen_s, wait_s, win_s, lose_s;
    // lenient, timeout 50
    logic [1:0] round_l, color_l, hs_l;
    logic       cen_l, wait_l, win_l, lose_l;
    // strict, timeout disabled
    logic [1:0] round_n, color_n, hs_n;
    logic       cen_n, wait_n, win_n, lose_n;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] tb_seed;
    logic [1:0]  exp_seq [3];

    always #5 clk = ~clk;

    // Free-running seed reference: cleared by reset, +1 per clock.
    always @(posedge clk or negedge rst)
        if (!rst) tb_seed <= 16'd0;
        else      tb_seed <= tb_seed + 16'd1;

    simon_core_param #(.NUM_COLORS(4), .MAX_ROUNDS(3), .SHOW_CYCLES(4), .GAP_CYCLES(2),
                       .TIMEOUT_CYCLES(50), .STRICT(1)) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .btn_pulse(btn_pulse), .btn_idx(btn_idx),
        .round(round_s), .color(color_s), .color_en(cen_s), .wait_in(wait_s),
        .win(win_s), .lose(lose_s), .high_score(hs_s));

    simon_core_param #(.NUM_COLORS(4), .MAX_ROUNDS(3), .SHOW_CYCLES(4), .GAP_CYCLES(2),
                       .TIMEOUT_CYCLES(50), .STRICT(0)) dut_l (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .btn_pulse(btn_pulse), .btn_idx(btn_idx),
        .round(round_l), .color(color_l), .color_en(cen_l), .wait_in(wait_l),
        .win(win_l), .lose(lose_l), .high_score(hs_l));

    simon_core_param #(.NUM_COLORS(4), .MAX_ROUNDS(3), .SHOW_CYCLES(4), .GAP_CYCLES(2),
                       .TIMEOUT_CYCLES(0), .STRICT(1)) dut_n (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .btn_pulse(btn_pulse), .btn_idx(btn_idx),
        .round(round_n), .color(color_n), .color_en(cen_n), .wait_in(wait_n),
        .win(win_n), .lose(lose_n), .high_score(hs_n));

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge: pulse start, predict the three colours from the
    // seed the DUT will sample at the coming edge. Returns in the ADD cycle.
    task automatic start_game(input logic with_btn, input logic [2:0] idx);
        logic [15:0] l;
        logic [7:0]  lo;
        l = tb_seed | 16'h0001;
        for (int k = 0; k < 3; k++) begin
            lo = l[7:0];
            exp_seq[k] = lo[1:0];  // % 4
            l = lfsr_step(l);
        end
        start_pulse = 1'b1;
        btn_pulse   = with_btn;
        btn_idx     = idx;
        tick();
        start_pulse = 1'b0;
        btn_pulse   = 1'b0;
    endtask

    // From the ADD cycle: check full playback of round r, end in WAIT_IN.
    task automatic play_round(input int r);
        tick();
        chk($sformatf("round_r%0d", r), 32'(round_s), 32'(r));
        for (int i = 0; i < r; i++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("cen_on_r%0d_i%0d_c%0d", r, i, c), 32'(cen_s), 32'd1);
                chk($sformatf("color_r%0d_i%0d_c%0d", r, i, c), 32'(color_s), 32'(exp_seq[i]));
                tick();
            end
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("cen_gap_r%0d_i%0d_g%0d", r, i, g), 32'(cen_s), 32'd0);
                chk($sformatf("wait_gap_r%0d_i%0d_g%0d", r, i, g), 32'(wait_s), 32'd0);
                tick();
            end
        end
        chk($sformatf("wait_in_r%0d", r), 32'(wait_s), 32'd1);
    endtask

    task automatic press(input logic [2:0] idx);
        btn_pulse = 1'b1;
        btn_idx   = idx;
        tick();
        btn_pulse = 1'b0;
    endtask

    initial begin
        // ---- reset / idle ----
        repeat (3) @(negedge clk);
        chk("rst_cen", 32'(cen_s), 32'd0);
        chk("rst_round", 32'(round_s), 32'd0);
        rst = 1'b1;
        repeat (10) tick();
        press(3'd1);
        chk("idle_round", 32'(round_s), 32'd0);
        chk("idle_color", 32'(color_s), 32'd0);
        chk("idle_cen", 32'(cen_s), 32'd0);
        chk("idle_wait", 32'(wait_s), 32'd0);
        chk("idle_win", 32'(win_s), 32'd0);
        chk("idle_lose", 32'(lose_s), 32'd0);
        chk("idle_hs", 32'(hs_s), 32'd0);

        // ---- game 1: playback timing, strict loss in round 2 ----
        start_game(1'b0, 3'd0);
        chk("add_round0", 32'(round_s), 32'd0);
        chk("add_cen0", 32'(cen_s), 32'd0);
        play_round(1);
        press({1'b0, exp_seq[0]});
        chk("g1_after_r1_wait", 32'(wait_s), 32'd0);
        play_round(2);
        press({1'b0, exp_seq[0]});
        chk("g1_mid_wait", 32'(wait_s), 32'd1);
        chk("g1_mid_lose", 32'(lose_s), 32'd0);
        press({1'b0, exp_seq[1] + 2'd1});
        chk("g1_lose", 32'(lose_s), 32'd1);
        chk("g1_wait_off", 32'(wait_s), 32'd0);
        chk("g1_hs", 32'(hs_s), 32'd1);
        press({1'b0, exp_seq[1]});
        chk("g1_lose_hold", 32'(lose_s), 32'd1);
        chk("g1_round_hold", 32'(round_s), 32'd2);
        chk("g1_hs_hold", 32'(hs_s), 32'd1);

        // ---- game 2: full win ----
        start_game(1'b0, 3'd0);
        chk("g2_lose_clr", 32'(lose_s), 32'd0);
        for (int r = 1; r <= 3; r++) begin
            play_round(r);
            for (int k = 0; k < r; k++) press({1'b0, exp_seq[k]});
        end
        chk("g2_win", 32'(win_s), 32'd1);
        chk("g2_hs", 32'(hs_s), 32'd3);
        chk("g2_round", 32'(round_s), 32'd3);
        chk("g2_wait_off", 32'(wait_s), 32'd0);

        // ---- game 3: ignored index, start beats a wrong press, async reset ----
        start_game(1'b0, 3'd0);
        chk("g3_win_clr", 32'(win_s), 32'd0);
        play_round(1);
        press(3'd5);
        chk("idx5_wait", 32'(wait_s), 32'd1);
        chk("idx5_lose", 32'(lose_s), 32'd0);
        start_game(1'b1, {1'b0, exp_seq[0] + 2'd1});
        chk("prio_lose", 32'(lose_s), 32'd0);
        chk("prio_round0", 32'(round_s), 32'd0);
        tick();
        chk("prio_round1", 32'(round_s), 32'd1);
        chk("prio_cen", 32'(cen_s), 32'd1);
        chk("prio_color", 32'(color_s), 32'(exp_seq[0]));
        tick();
        chk("pre_rst_cen", 32'(cen_s), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_cen", 32'(cen_s), 32'd0);
        chk("async_rst_round", 32'(round_s), 32'd0);
        chk("async_rst_hs", 32'(hs_s), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ---- timeout: strict loses, lenient replays, disabled waits ----
        start_game(1'b0, 3'd0);
        play_round(1);
        repeat (49) tick();
        chk("to49_wait_l", 32'(wait_l), 32'd1);
        chk("to49_wait_s", 32'(wait_s), 32'd1);
        tick();
        chk("to50_lose_s", 32'(lose_s), 32'd1);
        chk("to50_hs_s", 32'(hs_s), 32'd0);
        chk("to50_wait_l", 32'(wait_l), 32'd0);
        chk("to50_cen_l", 32'(cen_l), 32'd1);
        chk("to50_color_l", 32'(color_l), 32'(exp_seq[0]));
        chk("to50_round_l", 32'(round_l), 32'd1);
        chk("to50_lose_l", 32'(lose_l), 32'd0);
        chk("to50_wait_n", 32'(wait_n), 32'd1);
        repeat (1000) tick();
        chk("to_off_wait_n", 32'(wait_n), 32'd1);
        chk("to_off_lose_n", 32'(lose_n), 32'd0);
        chk("to_off_round_n", 32'(round_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
